// File: rtl/spi_slave_stream_pkg.sv
// rtl/spi_slave_stream_pkg.sv - shared types and constants for the QOA host-link SPI slave
package qoa_spi_pkg;

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} spi_state_e;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_slave_stream_if.sv
// rtl/spi_slave_stream_if.sv - RX/TX valid/ready word streams between SPI slave and decoder core
interface spi_slave_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_slave_stream_sync_fifo.sv
// rtl/spi_slave_stream_sync_fifo.sv - first-word-fall-through FIFO with push/pop in the same cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             pop_fire;
    logic             push_fire;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_fire   = pop_ready & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_fire  = push_valid & (~full | pop_fire);
    assign push_ready = ~full;
    assign pop_valid  = ~empty;
    assign pop_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_slave_stream.sv
// rtl/spi_slave_stream.sv - oversampled SPI slave (any mode, any word width) with RX/TX stream FIFOs
module spi_slave_stream
    import qoa_spi_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               RX_DEPTH  = 4,
    parameter int               TX_DEPTH  = 4,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b0,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sclk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    spi_slave_stream_if.slave  stream,
    output logic               cs_active,
    output logic               frame_end,
    output logic               rx_overflow,
    output logic               tx_underrun,
    input  logic               clr_err
);
    localparam int CNT_W = cnt_width(DATA_W);

    spi_state_e        state;
    logic [SYNC_STAGES:0]   sclk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic              sclk_sync, sclk_hist, cs_sync, mosi_sync;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit, load_pending, in_frame, word_start;
    logic [DATA_W-1:0] rx_shreg, rx_next, tx_shreg, tx_head;
    logic              tx_avail, rx_push, rx_space, rx_drop;

    assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
    assign sclk_hist = sclk_pipe[SYNC_STAGES];
    assign cs_sync   = cs_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

    assign lead_edge   = (sclk_hist == CPOL) && (sclk_sync != CPOL);
    assign trail_edge  = (sclk_hist != CPOL) && (sclk_sync == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    assign in_frame   = (state == ACTIVE) && !cs_sync;
    assign word_start = ((state == IDLE) && !cs_sync) || (load_pending && in_frame);
    assign rx_next    = MSB_FIRST ? {rx_shreg[DATA_W-2:0], mosi_sync}
                                  : {mosi_sync, rx_shreg[DATA_W-1:1]};
    assign rx_push    = in_frame && sample_edge && last_bit;
    assign rx_drop    = rx_push && !rx_space && !(stream.rx_valid && stream.rx_ready);

    assign spi_miso    = MSB_FIRST ? tx_shreg[DATA_W-1] : tx_shreg[0];
    assign spi_miso_oe = cs_active;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_data  (rx_next),
        .push_valid (rx_push),
        .push_ready (rx_space),
        .pop_data   (stream.rx_data),
        .pop_valid  (stream.rx_valid),
        .pop_ready  (stream.rx_ready)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_data  (stream.tx_data),
        .push_valid (stream.tx_valid),
        .push_ready (stream.tx_ready),
        .pop_data   (tx_head),
        .pop_valid  (tx_avail),
        .pop_ready  (word_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // CS_N chain starts "selected" so a frame already in progress is never joined.
            sclk_pipe    <= {(SYNC_STAGES + 1){CPOL}};
            cs_pipe      <= '0;
            mosi_pipe    <= '0;
            state        <= ARM;
            cs_active    <= 1'b0;
            frame_end    <= 1'b0;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            rx_shreg     <= '0;
            tx_shreg     <= '0;
            rx_overflow  <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            sclk_pipe    <= {sclk_pipe[SYNC_STAGES-1:0], spi_sclk};
            cs_pipe      <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
            mosi_pipe    <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            frame_end    <= 1'b0;
            load_pending <= 1'b0;
            rx_overflow  <= (rx_overflow & ~clr_err) | rx_drop;
            tx_underrun  <= (tx_underrun & ~clr_err) | (word_start & ~tx_avail);

            case (state)
                ARM: begin
                    if (cs_sync) state <= IDLE;
                end
                IDLE: begin
                    if (!cs_sync) begin
                        state     <= ACTIVE;
                        cs_active <= 1'b1;
                        bit_cnt   <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_sync) begin
                        state     <= IDLE;
                        cs_active <= 1'b0;
                        frame_end <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shreg     <= rx_next;
                            bit_cnt      <= last_bit ? '0 : bit_cnt + 1'b1;
                            load_pending <= last_bit;
                        end
                        // bit_cnt==0 marks the first shift edge of a word, which must present bit 0.
                        if (shift_edge && (bit_cnt != '0)) begin
                            tx_shreg <= MSB_FIRST ? {tx_shreg[DATA_W-2:0], 1'b0}
                                                  : {1'b0, tx_shreg[DATA_W-1:1]};
                        end
                    end
                end
                default: state <= ARM;
            endcase

            if (word_start) begin
                tx_shreg <= tx_avail ? tx_head : FILL_WORD;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_stream.sv
// tb/tb_spi_slave_stream.sv - randomized self-checking bench: mode-0 MSB-first and mode-3 LSB-first instances
module tb_spi_slave_stream;
    localparam logic [7:0] FILL0 = 8'hC3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sclk = 2'b10;
    logic [1:0] cs_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [1:0] miso, oe, cs_act, fend, ovf, unr;
    logic [1:0] rx_ready = 2'b00;
    logic [1:0] tx_valid = 2'b00;
    logic [1:0] rx_valid, tx_ready;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];
    int         fe_cnt [2];
    int         checks = 0;
    int         failures = 0;

    spi_slave_stream_if #(.DATA_W(8)) s0 ();
    spi_slave_stream_if #(.DATA_W(8)) s1 ();

    assign s0.rx_ready = rx_ready[0];
    assign s1.rx_ready = rx_ready[1];
    assign s0.tx_valid = tx_valid[0];
    assign s1.tx_valid = tx_valid[1];
    assign s0.tx_data  = tx_data[0];
    assign s1.tx_data  = tx_data[1];
    assign rx_valid[0] = s0.rx_valid;
    assign rx_valid[1] = s1.rx_valid;
    assign rx_data[0]  = s0.rx_data;
    assign rx_data[1]  = s1.rx_data;
    assign tx_ready[0] = s0.tx_ready;
    assign tx_ready[1] = s1.tx_ready;

    spi_slave_stream #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .FILL_WORD(FILL0)) dut0 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .stream(s0), .cs_active(cs_act[0]),
        .frame_end(fend[0]), .rx_overflow(ovf[0]), .tx_underrun(unr[0]), .clr_err(clr[0])
    );

    spi_slave_stream #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .FILL_WORD(8'h00)) dut1 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .stream(s1), .cs_active(cs_act[1]),
        .frame_end(fend[1]), .rx_overflow(ovf[1]), .tx_underrun(unr[1]), .clr_err(clr[1])
    );

    always #5 clk = ~clk;

    initial begin
        fe_cnt[0] = 0;
        fe_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (fend[0]) fe_cnt[0] <= fe_cnt[0] + 1;
        if (fend[1]) fe_cnt[1] <= fe_cnt[1] + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic push_tx(input int d, input logic [7:0] w);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        @(negedge clk);
        tx_valid[d] = 1'b0;
    endtask

    task automatic pop_rx(input int d, output logic [7:0] w, output logic ok);
        ok = rx_valid[d];
        w  = rx_data[d];
        if (ok) begin
            rx_ready[d] = 1'b1;
            @(negedge clk);
            rx_ready[d] = 1'b0;
        end
    endtask

    task automatic pulse_clr(input int d);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0;
    endtask

    // Ideal SPI master: instance 0 is mode 0 MSB first, instance 1 is mode 3 LSB first.
    task automatic spi_bits(input int d, input logic [7:0] mo[$], input int from, input int to,
                            inout logic [7:0] mi[$]);
        logic       cpol, cpha;
        logic [7:0] cur;
        logic [7:0] word;
        int         pos;
        cpol = (d == 1);
        cpha = (d == 1);
        cur  = '0;
        for (int b = from; b < to; b++) begin
            pos  = (d == 0) ? 7 - (b % 8) : b % 8;
            word = mo[b / 8];
            if (!cpha) mosi[d] = word[pos];
            half();
            sclk[d] = ~cpol;
            if (cpha) mosi[d] = word[pos];
            else      cur[pos] = miso[d];
            half();
            sclk[d] = cpol;
            if (cpha) cur[pos] = miso[d];
            if (b % 8 == 7) begin
                mi.push_back(cur);
                cur = '0;
            end
        end
    endtask

    task automatic frame(input int d, input logic [7:0] mo[$], input int nbits, output logic [7:0] mi[$]);
        mi = {};
        cs_n[d] = 1'b0;
        spi_bits(d, mo, 0, nbits, mi);
        half();
        cs_n[d] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({miso[d], oe[d], rx_valid[d], tx_ready[d], cs_act[d], fend[d], ovf[d], unr[d]} !== 8'b0001_0000) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %b expected 00010000", d,
                         {miso[d], oe[d], rx_valid[d], tx_ready[d], cs_act[d], fend[d], ovf[d], unr[d]});
            end
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_mode0_basic();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] w;
        logic       ok;
        int         fe0;
        fe0 = fe_cnt[0];
        push_tx(0, 8'h3C);
        push_tx(0, 8'h96);
        mo = {8'hA5};
        frame(0, mo, 8, mi);
        checks++;
        if (mi.size() != 1 || mi[0] !== 8'h3C) begin
            failures++;
            $display("FAIL mode0_miso: got %h (n=%0d) expected 3c", mi[0], mi.size());
        end
        pop_rx(0, w, ok);
        checks++;
        if ({ok, w} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL mode0_rx: got valid=%b data=%h expected valid=1 data=a5", ok, w);
        end
        checks++;
        if (rx_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL mode0_single_pop: rx_valid=%b expected 0", rx_valid[0]);
        end
        checks++;
        if (unr[0] !== 1'b0 || fe_cnt[0] != fe0 + 1) begin
            failures++;
            $display("FAIL mode0_flags: underrun=%b frame_ends=%0d expected 0 and %0d", unr[0], fe_cnt[0] - fe0, 1);
        end
    endtask

    task automatic test_random_mode0();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] exp_mi[$];
        logic [7:0] w;
        logic       ok;
        int         nw, npush;
        for (int it = 0; it < 6; it++) begin
            mo = {};
            exp_mi = {};
            nw = $urandom_range(1, 3);
            npush = $urandom_range(0, nw + 1);
            pulse_clr(0);
            for (int i = 0; i < nw; i++) mo.push_back(8'($urandom));
            // A frame of nw words has nw+1 word starts while CS stays low after the last bit.
            for (int i = 0; i < npush; i++) begin
                w = 8'($urandom);
                push_tx(0, w);
                exp_mi.push_back(w);
            end
            while (exp_mi.size() < nw) exp_mi.push_back(FILL0);
            frame(0, mo, 8 * nw, mi);
            for (int i = 0; i < nw; i++) begin
                checks++;
                if (mi[i] !== exp_mi[i]) begin
                    failures++;
                    $display("FAIL random_miso it%0d w%0d: got %h expected %h", it, i, mi[i], exp_mi[i]);
                end
                pop_rx(0, w, ok);
                checks++;
                if ({ok, w} !== {1'b1, mo[i]}) begin
                    failures++;
                    $display("FAIL random_rx it%0d w%0d: got valid=%b data=%h expected %h", it, i, ok, w, mo[i]);
                end
            end
            checks++;
            if (unr[0] !== (npush < nw + 1) || rx_valid[0] !== 1'b0 || tx_ready[0] !== 1'b1) begin
                failures++;
                $display("FAIL random_state it%0d: underrun=%b rx_valid=%b tx_ready=%b expected %b 0 1",
                         it, unr[0], rx_valid[0], tx_ready[0], npush < nw + 1);
            end
        end
    endtask

    task automatic test_mode3();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] t0, t1, w;
        logic       ok;
        t0 = 8'($urandom);
        t1 = 8'($urandom);
        push_tx(1, t0);
        push_tx(1, t1);
        mo = {8'h01, 8'h80};
        frame(1, mo, 16, mi);
        checks++;
        if (mi[0] !== t0 || mi[1] !== t1) begin
            failures++;
            $display("FAIL mode3_miso: got %h %h expected %h %h", mi[0], mi[1], t0, t1);
        end
        pop_rx(1, w, ok);
        checks++;
        if ({ok, w} !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL mode3_rx0: got valid=%b data=%h expected 01", ok, w);
        end
        pop_rx(1, w, ok);
        checks++;
        if ({ok, w} !== {1'b1, 8'h80}) begin
            failures++;
            $display("FAIL mode3_rx1: got valid=%b data=%h expected 80", ok, w);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] w;
        logic       ok;
        pulse_clr(0);
        mo = {8'h12, 8'h34};
        frame(0, mo, 16, mi);
        checks++;
        if (mi[0] !== FILL0 || mi[1] !== FILL0 || unr[0] !== 1'b1) begin
            failures++;
            $display("FAIL underrun_fill: got %h %h underrun=%b expected %h %h 1", mi[0], mi[1], unr[0], FILL0, FILL0);
        end
        pulse_clr(0);
        checks++;
        if (unr[0] !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear: underrun=%b expected 0", unr[0]);
        end
        pop_rx(0, w, ok);
        pop_rx(0, w, ok);
    endtask

    task automatic test_overflow();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] w;
        logic       ok;
        pulse_clr(0);
        for (int i = 0; i < 5; i++) mo.push_back(8'($urandom));
        frame(0, mo, 40, mi);
        checks++;
        if (ovf[0] !== 1'b1 || tx_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag: overflow=%b tx_ready=%b expected 1 1", ovf[0], tx_ready[0]);
        end
        for (int i = 0; i < 4; i++) begin
            pop_rx(0, w, ok);
            checks++;
            if ({ok, w} !== {1'b1, mo[i]}) begin
                failures++;
                $display("FAIL overflow_keep w%0d: got valid=%b data=%h expected %h", i, ok, w, mo[i]);
            end
        end
        checks++;
        if (rx_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL overflow_drop: rx_valid=%b expected 0", rx_valid[0]);
        end
        pulse_clr(0);
    endtask

    task automatic test_partial();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] w;
        logic       ok;
        int         fe0;
        fe0 = fe_cnt[0];
        mo = {8'($urandom)};
        frame(0, mo, 5, mi);
        checks++;
        if (rx_valid[0] !== 1'b0 || fe_cnt[0] != fe0 + 1) begin
            failures++;
            $display("FAIL partial_discard: rx_valid=%b frame_ends=%0d expected 0 and 1", rx_valid[0], fe_cnt[0] - fe0);
        end
        mo = {8'($urandom)};
        frame(0, mo, 8, mi);
        pop_rx(0, w, ok);
        checks++;
        if ({ok, w} !== {1'b1, mo[0]}) begin
            failures++;
            $display("FAIL partial_realign: got valid=%b data=%h expected %h", ok, w, mo[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mo[$];
        logic [7:0] mi[$];
        logic [7:0] w;
        logic       ok;
        int         fe0;
        mo = {8'($urandom)};
        mi = {};
        push_tx(0, 8'hFF);
        cs_n[0] = 1'b0;
        spi_bits(0, mo, 0, 4, mi);
        checks++;
        if (cs_act[0] !== 1'b1 || oe[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_selected: cs_active=%b oe=%b expected 1 1", cs_act[0], oe[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso[0], oe[0], rx_valid[0], tx_ready[0], cs_act[0], ovf[0], unr[0]} !== 7'b0001000) begin
            failures++;
            $display("FAIL midreset_outputs: got %b expected 0001000",
                     {miso[0], oe[0], rx_valid[0], tx_ready[0], cs_act[0], ovf[0], unr[0]});
        end
        rst = 1'b0;
        fe0 = fe_cnt[0];
        spi_bits(0, mo, 4, 8, mi);
        half();
        cs_n[0] = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (rx_valid[0] !== 1'b0 || fe_cnt[0] != fe0 || oe[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ignored: rx_valid=%b frame_ends=%0d oe=%b expected 0 0 0",
                     rx_valid[0], fe_cnt[0] - fe0, oe[0]);
        end
        mo = {8'($urandom)};
        frame(0, mo, 8, mi);
        pop_rx(0, w, ok);
        checks++;
        if ({ok, w} !== {1'b1, mo[0]}) begin
            failures++;
            $display("FAIL midreset_recover: got valid=%b data=%h expected %h", ok, w, mo[0]);
        end
    endtask

    initial begin
        tx_data[0] = '0;
        tx_data[1] = '0;
        test_reset();
        test_mode0_basic();
        test_random_mode0();
        test_mode3();
        test_underrun();
        test_overflow();
        test_partial();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
